// File: rtl/eth_tx_checker_if.sv
// Ethernet TX AXI-Stream style bus between a frame source and eth_tx_checker.
// The master drives the beat; the slave returns tready.
interface eth_tx_checker_if #(
  parameter int DATA_W = 64
);
  logic                eth_tx_tvalid;
  logic [DATA_W-1:0]   eth_tx_tdata;
  logic [DATA_W/8-1:0] eth_tx_tkeep;
  logic                eth_tx_tlast;
  logic                eth_tx_tuser;
  logic                eth_tx_tready;

  modport master (
    output eth_tx_tvalid, eth_tx_tdata, eth_tx_tkeep, eth_tx_tlast, eth_tx_tuser,
    input  eth_tx_tready
  );

  modport slave (
    input  eth_tx_tvalid, eth_tx_tdata, eth_tx_tkeep, eth_tx_tlast, eth_tx_tuser,
    output eth_tx_tready
  );
endinterface

// File: rtl/eth_tx_checker.sv
// eth_tx_checker: sinks an Ethernet/IPv4/UDP frame stream, checks header
// fields, length and framing, and reports one result strobe per frame.
// Optional feature: define ETH_TX_CHECK_CSUM_EN to verify the IPv4 header
// checksum; without it the csum error bit is held at 0.
module eth_tx_checker #(
  parameter int         C_DATA_WIDTH  = 64,
  parameter logic [7:0] READY_PATTERN = 8'hFF,
  parameter logic [7:0] MAX_BEATS     = 8'd190
) (
  input  logic               eth_clk,
  input  logic               sys_rst_n,
  eth_tx_checker_if.slave    eth_tx,
  output logic               frame_done,
  output logic               frame_ok,
  output logic [5:0]         frame_err,
  output logic [15:0]        frame_len,
  output logic [15:0]        udp_dst_port,
  output logic [31:0]        frame_cnt,
  output logic [31:0]        err_cnt
);
  localparam int KEEP_W = C_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_BODY = 3'd2,
    ST_DROP = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Number of qualified bytes in one beat.
  function automatic logic [15:0] keep_bytes(input logic [KEEP_W-1:0] keep);
    logic [15:0] cnt;
    cnt = 16'd0;
    for (int i = 0; i < KEEP_W; i++) begin
      cnt = cnt + {15'd0, keep[i]};
    end
    return cnt;
  endfunction

  state_t                  state_r, state_nxt_s;
  logic [2:0]              cyc_r, cyc_nxt_s;
  logic                    ready_r;
  logic                    accept_s;
  logic [C_DATA_WIDTH-1:0] swap_s;
  logic [7:0]              beat_r, beat_idx_s;
  logic [15:0]             byte_cnt_r, byte_base_s, len_next_s;
  logic                    over_s;
  logic [15:0]             ethertype_r, ip_len_r, dport_r;
  logic [7:0]              ver_ihl_r, proto_r;
  logic [16:0]             ip_plus_s, exp_len_s;
  logic                    csum_bad_s;
  logic                    runt_s, hdr_s, len_s, csum_s;
  logic [5:0]              err_s;
  logic                    frame_done_r, frame_ok_r;
  logic [5:0]              frame_err_r;
  logic [15:0]             frame_len_r, udp_dst_port_r;
  logic [31:0]             frame_cnt_r, err_cnt_r;

  assign accept_s    = eth_tx.eth_tx_tvalid & ready_r;
  assign cyc_nxt_s   = cyc_r + 3'd1;
  // In IDLE the beat on the bus is always beat 0 of a new frame.
  assign beat_idx_s  = (state_r == ST_IDLE) ? 8'd0 : beat_r;
  assign byte_base_s = (state_r == ST_IDLE) ? 16'd0 : byte_cnt_r;
  assign len_next_s  = byte_base_s + keep_bytes(eth_tx.eth_tx_tkeep);
  // Accepting beat index >= MAX_BEATS makes the beat count exceed MAX_BEATS.
  assign over_s      = (beat_idx_s >= MAX_BEATS);
  assign ip_plus_s   = {1'b0, ip_len_r} + 17'd14;
  assign exp_len_s   = (ip_plus_s < 17'd60) ? 17'd60 : ip_plus_s;

  // Byte swap so frame byte 0 of the beat lands in bits [63:56].
  always_comb begin
    swap_s = {C_DATA_WIDTH{1'b0}};
    for (int i = 0; i < KEEP_W; i++) begin
      swap_s[C_DATA_WIDTH-1-8*i -: 8] = eth_tx.eth_tx_tdata[8*i +: 8];
    end
  end

  // State register, free-running cycle counter and registered tready.
  // tready is computed one cycle ahead so it equals READY_PATTERN[cyc]
  // while the FSM is outside DONE; it is low while reset is held.
  always_ff @(posedge eth_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r <= ST_IDLE;
      cyc_r   <= 3'd0;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cyc_r   <= cyc_nxt_s;
      ready_r <= READY_PATTERN[cyc_nxt_s] & (state_nxt_s != ST_DONE);
    end
  end

  // Next-state decode; a tvalid-low stall keeps the current state.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = eth_tx.eth_tx_tlast ? ST_DONE : ST_HDR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (accept_s) begin
          if (eth_tx.eth_tx_tlast) begin
            state_nxt_s = ST_DONE;
          end else if (beat_idx_s == 8'd4) begin
            state_nxt_s = ST_BODY;
          end else begin
            state_nxt_s = ST_HDR;
          end
        end else begin
          state_nxt_s = ST_HDR;
        end
      end
      ST_BODY: begin
        if (accept_s) begin
          if (eth_tx.eth_tx_tlast) begin
            state_nxt_s = ST_DONE;
          end else if (over_s) begin
            state_nxt_s = ST_DROP;
          end else begin
            state_nxt_s = ST_BODY;
          end
        end else begin
          state_nxt_s = ST_BODY;
        end
      end
      ST_DROP: begin
        if (accept_s && eth_tx.eth_tx_tlast) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DROP;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Beat/byte counters and header field capture on accepted beats only.
  always_ff @(posedge eth_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      beat_r      <= 8'd0;
      byte_cnt_r  <= 16'd0;
      ethertype_r <= 16'd0;
      ver_ihl_r   <= 8'd0;
      ip_len_r    <= 16'd0;
      proto_r     <= 8'd0;
      dport_r     <= 16'd0;
    end else if (accept_s) begin
      beat_r     <= (beat_idx_s == 8'hFF) ? 8'hFF : beat_idx_s + 8'd1;
      byte_cnt_r <= len_next_s;
      case (beat_idx_s)
        8'd0: dport_r <= 16'd0;
        8'd1: begin
          ethertype_r <= swap_s[31:16];
          ver_ihl_r   <= swap_s[15:8];
        end
        8'd2: begin
          ip_len_r <= swap_s[63:48];
          proto_r  <= swap_s[7:0];
        end
        8'd4: dport_r <= swap_s[31:16];
        default: dport_r <= dport_r;
      endcase
    end
  end

`ifdef ETH_TX_CHECK_CSUM_EN
  // 16-bit ones-complement add with end-around carry.
  function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[15:0] + {15'd0, sum[16]};
  endfunction

  logic [15:0] csum_r;

  // Running ones-complement sum of the ten IPv4 header words (bytes 14-33).
  always_ff @(posedge eth_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      csum_r <= 16'h0000;
    end else if (accept_s) begin
      case (beat_idx_s)
        8'd0:       csum_r <= 16'h0000;
        8'd1:       csum_r <= ones_add(csum_r, swap_s[15:0]);
        8'd2, 8'd3: csum_r <= ones_add(ones_add(csum_r, swap_s[63:48]),
                                       ones_add(swap_s[47:32],
                                                ones_add(swap_s[31:16], swap_s[15:0])));
        8'd4:       csum_r <= ones_add(csum_r, swap_s[63:48]);
        default:    csum_r <= csum_r;
      endcase
    end
  end

  assign csum_bad_s = (csum_r != 16'hFFFF);
`else
  logic unused_s;
  assign unused_s   = ^swap_s[47:32];
  assign csum_bad_s = 1'b0;
`endif

  // Error vector for the frame ending on the current beat.
  always_comb begin
    runt_s = (beat_idx_s <= 8'd4);
    if (runt_s) begin
      hdr_s  = 1'b0;
      len_s  = 1'b0;
      csum_s = 1'b0;
    end else begin
      hdr_s  = (ethertype_r != 16'h0800) | (ver_ihl_r != 8'h45) | (proto_r != 8'h11);
      len_s  = ({1'b0, len_next_s} != exp_len_s);
      csum_s = csum_bad_s;
    end
    err_s = {(state_r == ST_DROP), runt_s, eth_tx.eth_tx_tuser, len_s, csum_s, hdr_s};
  end

  // Result registers and saturating statistics, updated on the tlast beat.
  always_ff @(posedge eth_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_done_r   <= 1'b0;
      frame_ok_r     <= 1'b0;
      frame_err_r    <= 6'd0;
      frame_len_r    <= 16'd0;
      udp_dst_port_r <= 16'd0;
      frame_cnt_r    <= 32'd0;
      err_cnt_r      <= 32'd0;
    end else if (accept_s && eth_tx.eth_tx_tlast) begin
      frame_done_r   <= 1'b1;
      frame_ok_r     <= ~|err_s;
      frame_err_r    <= err_s;
      frame_len_r    <= len_next_s;
      udp_dst_port_r <= dport_r;
      frame_cnt_r    <= (frame_cnt_r == 32'hFFFF_FFFF) ? frame_cnt_r : frame_cnt_r + 32'd1;
      if ((|err_s) && (err_cnt_r != 32'hFFFF_FFFF)) begin
        err_cnt_r <= err_cnt_r + 32'd1;
      end
    end else begin
      frame_done_r <= 1'b0;
    end
  end

  assign eth_tx.eth_tx_tready = ready_r;
  assign frame_done           = frame_done_r;
  assign frame_ok             = frame_ok_r;
  assign frame_err            = frame_err_r;
  assign frame_len            = frame_len_r;
  assign udp_dst_port         = udp_dst_port_r;
  assign frame_cnt            = frame_cnt_r;
  assign err_cnt              = err_cnt_r;
endmodule

// File: tb/tb_eth_tx_checker.sv
// Directed testbench for eth_tx_checker: a default instance (tready always
// high) and an instance with READY_PATTERN = 8'hAA.
`timescale 1ns/1ps
module tb_eth_tx_checker;
  logic eth_clk = 1'b0;
  logic sys_rst_n;
  always #5 eth_clk = ~eth_clk;

  eth_tx_checker_if #(.DATA_W(64)) bus_a ();
  eth_tx_checker_if #(.DATA_W(64)) bus_b ();

  logic        done_a, ok_a, done_b, ok_b;
  logic [5:0]  err_a, err_b;
  logic [15:0] len_a, port_a, len_b, port_b;
  logic [31:0] fcnt_a, ecnt_a, fcnt_b, ecnt_b;

  eth_tx_checker #(.C_DATA_WIDTH(64), .READY_PATTERN(8'hFF), .MAX_BEATS(8'd190)) dut_a (
    .eth_clk(eth_clk), .sys_rst_n(sys_rst_n), .eth_tx(bus_a),
    .frame_done(done_a), .frame_ok(ok_a), .frame_err(err_a), .frame_len(len_a),
    .udp_dst_port(port_a), .frame_cnt(fcnt_a), .err_cnt(ecnt_a));

  eth_tx_checker #(.C_DATA_WIDTH(64), .READY_PATTERN(8'hAA), .MAX_BEATS(8'd190)) dut_b (
    .eth_clk(eth_clk), .sys_rst_n(sys_rst_n), .eth_tx(bus_b),
    .frame_done(done_b), .frame_ok(ok_b), .frame_err(err_b), .frame_len(len_b),
    .udp_dst_port(port_b), .frame_cnt(fcnt_b), .err_cnt(ecnt_b));

  int         checks = 0;
  int         errors = 0;
  int         odd_bad = 0;
  logic [2:0] cyc_m;
  logic [7:0] fb [0:63];

  // Reference cycle counter: edges seen since reset release, modulo 8.
  always @(posedge eth_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) cyc_m <= 3'd0;
    else            cyc_m <= cyc_m + 3'd1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference 60-byte UDP frame; header checksum E36A is valid.
  task automatic build_frame();
    logic [8*42-1:0] hdr_v;
    hdr_v = {8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02,
             8'h08, 8'h00, 8'h45, 8'h00, 8'h00, 8'h2E, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
             8'hE3, 8'h6A, 8'h0A, 8'h00, 8'h00, 8'h01, 8'h0A, 8'h00, 8'h43, 8'h54,
             8'h30, 8'h39, 8'h37, 8'h76, 8'h00, 8'h1A, 8'h00, 8'h00};
    for (int i = 0; i < 64; i++) begin
      if (i < 42)      fb[i] = hdr_v[8*(41-i) +: 8];
      else if (i < 60) fb[i] = 8'(i);
      else             fb[i] = 8'h00;
    end
  endtask

  task automatic drive(input bit sel, input logic v, input logic [63:0] d, input logic [7:0] k,
                       input logic l, input logic u);
    if (sel) begin
      bus_b.eth_tx_tvalid = v; bus_b.eth_tx_tdata = d; bus_b.eth_tx_tkeep = k;
      bus_b.eth_tx_tlast = l;  bus_b.eth_tx_tuser = u;
    end else begin
      bus_a.eth_tx_tvalid = v; bus_a.eth_tx_tdata = d; bus_a.eth_tx_tkeep = k;
      bus_a.eth_tx_tlast = l;  bus_a.eth_tx_tuser = u;
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? bus_b.eth_tx_tready : bus_a.eth_tx_tready;
  endfunction

  // Sends nbeats beats (bytes from fb, zero beyond byte 63), with gap idle
  // cycles before each beat after the first; rst_beat >= 0 pulses reset
  // while that beat is on the bus and abandons the frame.
  task automatic send_frame(input bit sel, input int nbeats, input logic [7:0] last_keep,
                            input logic user, input int gap, input int rst_beat);
    logic [63:0] d;
    logic        acc;
    logic        last;
    for (int b = 0; b < nbeats; b++) begin
      if (b > 0) begin
        for (int g = 0; g < gap; g++) begin
          drive(sel, 1'b0, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF, 1'b1, 1'b1);
          @(negedge eth_clk);
        end
      end
      for (int i = 0; i < 8; i++) begin
        if (8*b+i < 64) d[8*i +: 8] = fb[8*b+i];
        else            d[8*i +: 8] = 8'h00;
      end
      last = (b == nbeats-1);
      drive(sel, 1'b1, d, last ? last_keep : 8'hFF, last, last ? user : 1'b0);
      if (b == rst_beat) begin
        #1 sys_rst_n = 1'b0;
        #1;
        check("rst_pulse_tready", rdy(sel), 1'b0);
        check("rst_pulse_fcnt_a", fcnt_a, 32'd0);
        check("rst_pulse_ecnt_a", ecnt_a, 32'd0);
        check("rst_pulse_fcnt_b", fcnt_b, 32'd0);
        check("rst_pulse_done", done_a, 1'b0);
        @(negedge eth_clk);
        drive(sel, 1'b0, 64'd0, 8'd0, 1'b0, 1'b0);
        sys_rst_n = 1'b1;
        @(negedge eth_clk);
        return;
      end
      acc = 1'b0;
      for (int w = 0; w < 64 && !acc; w++) begin
        acc = rdy(sel);
        if (acc && sel && (cyc_m[0] != 1'b1)) odd_bad++;
        if (acc && last) check("pre_tlast_done", sel ? done_b : done_a, 1'b0);
        @(negedge eth_clk);
      end
      if (!acc) begin
        check("beat_accept_timeout", 1'b0, 1'b1);
        drive(sel, 1'b0, 64'd0, 8'd0, 1'b0, 1'b0);
        return;
      end
    end
    drive(sel, 1'b0, 64'd0, 8'd0, 1'b0, 1'b0);
  endtask

  // Called at the first negedge after the tlast beat was accepted.
  task automatic check_frame(input bit sel, input string tag, input logic [5:0] exp_err,
                             input logic [15:0] exp_len, input bit chk_port,
                             input int exp_fcnt, input int exp_ecnt);
    check({tag, "_done"}, sel ? done_b : done_a, 1'b1);
    check({tag, "_ok"},   sel ? ok_b : ok_a, (exp_err == 6'd0));
    check({tag, "_err"},  sel ? err_b : err_a, exp_err);
    check({tag, "_len"},  sel ? len_b : len_a, exp_len);
    if (chk_port) check({tag, "_port"}, sel ? port_b : port_a, 16'h3776);
    check({tag, "_fcnt"}, sel ? fcnt_b : fcnt_a, 32'(exp_fcnt));
    check({tag, "_ecnt"}, sel ? ecnt_b : ecnt_a, 32'(exp_ecnt));
    @(negedge eth_clk);
    check({tag, "_strobe"}, sel ? done_b : done_a, 1'b0);
    check({tag, "_hold"},   sel ? err_b : err_a, exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int         fa;
    int         ea;
    logic [5:0] e;
    fa = 0;
    ea = 0;
    sys_rst_n = 1'b1;
    drive(1'b0, 1'b0, 64'd0, 8'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 64'd0, 8'd0, 1'b0, 1'b0);
    #2 sys_rst_n = 1'b0;
    repeat (2) @(negedge eth_clk);
    check("reset_tready", bus_a.eth_tx_tready, 1'b0);
    check("reset_done", done_a, 1'b0);
    check("reset_err", err_a, 6'd0);
    check("reset_len", len_a, 16'd0);
    check("reset_fcnt", fcnt_a, 32'd0);
    check("reset_ecnt", ecnt_a, 32'd0);
    sys_rst_n = 1'b1;
    @(negedge eth_clk);

    // Clean 8-beat UDP frame.
    build_frame();
    send_frame(1'b0, 8, 8'h0F, 1'b0, 0, -1);
    fa++;
    check_frame(1'b0, "good", 6'b000000, 16'd60, 1'b1, fa, ea);

    // Version/IHL 46, checksum adjusted so only hdr fires.
    build_frame();
    fb[14] = 8'h46;
    fb[24] = 8'hE2;
    send_frame(1'b0, 8, 8'h0F, 1'b0, 0, -1);
    fa++; ea++;
    check_frame(1'b0, "verihl", 6'b000001, 16'd60, 1'b1, fa, ea);

    // Corrupted header checksum.
    build_frame();
    fb[25] = 8'h6B;
`ifdef ETH_TX_CHECK_CSUM_EN
    e = 6'b000010;
`else
    e = 6'b000000;
`endif
    send_frame(1'b0, 8, 8'h0F, 1'b0, 0, -1);
    fa++;
    if (e != 6'd0) ea++;
    check_frame(1'b0, "csum", e, 16'd60, 1'b1, fa, ea);

    // Runt: tlast on beat 2.
    build_frame();
    send_frame(1'b0, 3, 8'hFF, 1'b0, 0, -1);
    fa++; ea++;
    check_frame(1'b0, "runt", 6'b010000, 16'd24, 1'b0, fa, ea);

    // tuser on the tlast beat, with stalls between beats.
    build_frame();
    send_frame(1'b0, 8, 8'h0F, 1'b1, 2, -1);
    fa++; ea++;
    check_frame(1'b0, "tuser", 6'b001000, 16'd60, 1'b1, fa, ea);

    // Clean frame with one stall cycle before every beat.
    build_frame();
    send_frame(1'b0, 8, 8'h0F, 1'b0, 1, -1);
    fa++;
    check_frame(1'b0, "stall", 6'b000000, 16'd60, 1'b1, fa, ea);

    // Exactly MAX_BEATS beats: length error only, not oversize.
    build_frame();
    send_frame(1'b0, 190, 8'hFF, 1'b0, 0, -1);
    fa++; ea++;
    check_frame(1'b0, "beats190", 6'b000100, 16'd1520, 1'b1, fa, ea);

    // 200 beats: oversize plus length error.
    build_frame();
    send_frame(1'b0, 200, 8'hFF, 1'b0, 0, -1);
    fa++; ea++;
    check_frame(1'b0, "beats200", 6'b100100, 16'd1600, 1'b1, fa, ea);

    // READY_PATTERN = AA instance, tvalid held high through every beat.
    build_frame();
    odd_bad = 0;
    send_frame(1'b1, 8, 8'h0F, 1'b0, 0, -1);
    check_frame(1'b1, "aa", 6'b000000, 16'd60, 1'b1, 1, 0);
    check("aa_odd_cyc_accepts", odd_bad, 0);

    // Reset pulsed while beat 3 is on the bus, then a clean frame.
    build_frame();
    send_frame(1'b0, 8, 8'h0F, 1'b0, 0, 3);
    build_frame();
    send_frame(1'b0, 8, 8'h0F, 1'b0, 0, -1);
    check_frame(1'b0, "after_rst", 6'b000000, 16'd60, 1'b1, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/eth_tx_checker.md
ETH_TX_CHECKER -- requirements
Module: eth_tx_checker

Interface
REQ-001 SHALL have parameter: C_DATA_WIDTH, 64, stream data width (only 64 supported).
REQ-002 SHALL have parameter: READY_PATTERN, 8'hFF, per-cycle tready mask, bit index = free-running 3-bit cycle counter.
REQ-003 SHALL have parameter: MAX_BEATS, 8'd190, beat count above which a frame is oversize.
REQ-004 SHALL have ports, in this order:
- eth_clk  in  1  sole clock.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- eth_tx_tvalid  in  1  beat valid.
- eth_tx_tdata  in  64  frame byte 0 on [7:0], byte 7 on [63:56].
- eth_tx_tkeep  in  8  bit i qualifies tdata byte i.
- eth_tx_tlast  in  1  last beat of frame.
- eth_tx_tuser  in  1  frame error marker, sampled on the tlast beat.
- eth_tx_tready  out  1  sink ready.
- frame_done  out  1  one-cycle result strobe.
- frame_ok  out  1  no error flag set, valid with frame_done.
- frame_err  out  6  {oversize, runt, tuser, len, csum, hdr}, valid with frame_done.
- frame_len  out  16  counted frame bytes.
- udp_dst_port  out  16  captured UDP destination port.
- frame_cnt  out  32  frames completed, saturating.
- err_cnt  out  32  frames with any error, saturating.

Function
REQ-005 SHALL accept a beat only when eth_tx_tvalid and eth_tx_tready are both 1.
REQ-006 SHALL drive eth_tx_tready = READY_PATTERN[cyc[2:0]] in IDLE/HDR/BODY/DROP, 0 in DONE; cyc increments every cycle.
REQ-007 SHALL byte-swap each beat internally (byte 0 into bits [63:56]) before field extraction.
REQ-008 SHALL implement states IDLE, HDR, BODY, DROP, DONE: IDLE->HDR on first accepted beat (beat 0 itself is captured); HDR->BODY after beat 4; BODY->DROP when beat count > MAX_BEATS; any of HDR/BODY/DROP->DONE on an accepted tlast beat; DONE->IDLE unconditionally after 1 cycle.
REQ-009 SHALL capture ethertype (bytes 12-13), ver/IHL (14), IP total length (16-17), protocol (23), IPv4 header bytes 14-33, UDP dst port (36-37).
REQ-010 SHALL set hdr when ethertype != 16'h0800, ver/IHL != 8'h45, or protocol != 8'h11.
REQ-011 SHALL count frame bytes as the sum of popcount(tkeep) over accepted beats, 16-bit wrapping.
REQ-012 SHALL set len when frame_len != max(IP total length + 14, 60).
REQ-013 SHALL set runt when tlast arrives on beat 0-4; hdr/len/csum are then forced 0.
REQ-014 SHALL set tuser when eth_tx_tuser = 1 on the tlast beat; oversize when DROP was entered.
REQ-015 SHALL assert frame_done exactly 1 cycle after the accepted tlast beat, with frame_ok = ~|frame_err; frame_err/frame_len/udp_dst_port hold until the next frame_done.
REQ-016 SHALL increment frame_cnt on every frame_done, and err_cnt when frame_ok = 0; both saturate at 32'hFFFF_FFFF.
REQ-017 SHALL treat tvalid = 0 mid-frame as a stall: no state, count, or capture change.

Reset
REQ-018 SHALL, on sys_rst_n = 0, immediately clear all outputs, counters, cyc, and state (to IDLE) regardless of eth_clk.
REQ-019 SHALL treat the first beat accepted after reset release as beat 0 of a new frame; no result for the interrupted frame.

Configuration
REQ-020 SHALL, with ETH_TX_CHECK_CSUM_EN defined, set csum when the ones-complement sum of the ten 16-bit words at bytes 14-33 (with end-around carry) != 16'hFFFF.
REQ-021 SHALL, without ETH_TX_CHECK_CSUM_EN, omit checksum logic and hold csum at 0.

Verification
REQ-022 SHALL cover: an 8-beat UDP frame (ethertype 0800, 45, total length 002E, checksum E36A, dst port 3776, last tkeep 8'h0F) -> frame_done 1 cycle after tlast, frame_ok=1, frame_len=60, udp_dst_port=16'h3776, frame_cnt=1.
REQ-023 SHALL cover: the same frame with byte 14 = 8'h46 -> frame_err=6'b000001, err_cnt=1.
REQ-024 SHALL cover: checksum changed to E36B -> frame_err=6'b000010 with ETH_TX_CHECK_CSUM_EN, frame_ok=1 without it.
REQ-025 SHALL cover: READY_PATTERN=8'hAA, tvalid held high -> beats accepted only on odd cyc, results identical to REQ-022.
REQ-026 SHALL cover: sys_rst_n pulsed low during beat 3 -> tready=0 and frame_cnt=0 at once; next clean frame -> frame_ok=1, frame_cnt=1.
REQ-027 SHALL cover: 3-beat frame with tlast on beat 2 -> frame_err=6'b010000, frame_len=24.
